m10_pll_scan_ctrl: RTL and testbench
====================================

# m10_pll_scan_ctrl

Drives the MAX 10 PLL dynamic-reconfiguration scan chain from the bit-serial configuration ROM `m10_pll_reconfig_file`. On `start`, the block:
- reads the 144-bit scan image for the requested speed profile one bit per cycle;
- shifts that image into the PLL;
- pulses `configupdate`, waits for `scandone`, then resets the PLL and waits for lock.

It sits in CLOCK_MGMT between the LTPI link-speed negotiation logic and the PLL IP.

## Interface
- `CHAIN_LEN`, 144: scan-chain length in bits; ROM bit index range is 0..`CHAIN_LEN`-1.
- `ROM_LATENCY`, 2: cycles from `rom_address` being driven to the matching `rom_q` being visible.
- `ARESET_CYCLES`, 8: width of the `pll_areset` pulse.
- `TIMEOUT_CYCLES`, 4096: bound on `scandone` wait and on `pll_locked` wait (only with the timeout feature).
- `clock` in 1: single clock; also used as PLL `scanclk`.
- `reset_n` in 1: reset is asynchronous and active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `profile` in 3: speed profile, latched on accepted `start`.
- `rom_address` out 11: {profile, bit index[7:0]}.
- `rom_rden` out 1: ROM read enable; must stay high for the whole read burst.
- `rom_q` in 1: ROM serial data.
- `scandata` out 1: PLL scan data.
- `scanclkena` out 1: PLL scan clock enable.
- `configupdate` out 1: PLL config update strobe.
- `scandone` in 1: PLL reconfiguration complete.
- `pll_areset` out 1: PLL asynchronous reset.
- `pll_locked` in 1: PLL lock indicator, synchronised externally.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky timeout flag; cleared by the next accepted `start`.

## Operation
States (enum) and transitions:
- **IDLE** → FETCH on `start`. Latches `profile`, clears the bit index and `error`.
- **FETCH**
  - Behaviour: `rom_rden`=1. `rom_address` increments by 1 per cycle from {profile,0} to {profile,143}, then holds.
  - Exit → SHIFT when the first valid `rom_q` is registered.
- **SHIFT**
  - Behaviour: `scandata` is registered from `rom_q`, with `scanclkena`=1 for exactly `CHAIN_LEN` consecutive cycles. Bit index 0 is shifted first, ascending.
  - `rom_rden` drops the cycle after the last `rom_q` is consumed.
  - Exit → UPDATE when the last bit has been shifted.
- **UPDATE**
  - Behaviour: `configupdate`=1 for one cycle.
  - Exit → WAIT_DONE.
- **WAIT_DONE**
  - Exit → ARESET when `scandone`=1.
  - Exit → FAIL on timeout (macro only).
- **ARESET**
  - Behaviour: `pll_areset`=1 for `ARESET_CYCLES` cycles.
  - Exit → WAIT_LOCK.
- **WAIT_LOCK**
  - Exit → IDLE when `pll_locked`=1, pulsing `done`.
  - Exit → FAIL on timeout (macro only).
- **FAIL**: sets `error`=1, then → IDLE. `done` is not pulsed.

Rules:
- `start` outside IDLE is ignored; a `profile` change mid-operation is ignored.
- `rom_rden` is never deasserted between the first and last ROM read. The ROM restarts its internal sequencer whenever `rden` falls.
- The bit index counter is 8 bits and must not wrap. It saturates at `CHAIN_LEN`-1 for addressing.
- Profiles 6 and 7 are passed through unchanged; the ROM distinguishes them.

## Timing
- Reset values: `rom_address`=0, `rom_rden`=0, `scandata`=0, `scanclkena`=0, `configupdate`=0, `pll_areset`=0, `busy`=0, `done`=0, `error`=0. State is IDLE.
- All outputs are registered.
- With `start` sampled at edge S:
  - `rom_rden`/`rom_address` index i are visible in cycle S+1+i.
  - `rom_q` bit i is visible in cycle S+1+i+`ROM_LATENCY`.
  - `scandata` bit i with `scanclkena`=1 is visible in cycle S+4+i. That is cycles S+4..S+147.
  - `rom_rden`=1 for cycles S+1..S+146.
  - `configupdate`=1 in cycle S+148.
  - `busy` rises in S+1.
- `scandone` already high on entry to WAIT_DONE is accepted on the next edge.
- `done` is coincident with `busy` falling.
- `reset_n` asserted mid-operation:
  - All outputs return to reset values immediately, including releasing `pll_areset`.
  - No partial `configupdate` is issued.

## Configuration
- `M10_PLL_SCAN_TIMEOUT_EN` defined:
  - A 13-bit counter bounds WAIT_DONE and WAIT_LOCK to `TIMEOUT_CYCLES` each.
  - On expiry the FSM enters FAIL, and `error` stays high until the next accepted `start`.
- `M10_PLL_SCAN_TIMEOUT_EN` undefined:
  - Both waits are unbounded.
  - FAIL is unreachable and `error` is tied 0.

## Structure
- Package `m10_pll_scan_pkg` holds:
  - the state enum `pll_scan_fsm_t`;
  - `CHAIN_LEN_C`=144;
  - `ROM_LATENCY_C`=2;
  - the profile encoding constants.
- One sub-module, `m10_pll_scan_timeout`: a load/run/expire counter, instantiated only under `M10_PLL_SCAN_TIMEOUT_EN`.
- `m10_pll_reconfig_file` is instantiated alongside the controller by the parent, not inside it.

## Test plan
- **Profile 0 read-back:** connect the real ROM and pulse `start` with `profile`=0. Required: 144 `scandata` bits in S+4..S+147 equal the ROM image for profile 0 (M counter high/low=0x0C, clk0/clk1 high/low=0x18), and `configupdate` pulses at S+148.
- **Profile 7 vs 6:** run both. Required: identical clock-counter bits; M counter bits match the ROM output for profiles 6/7 (0x14).
- **Completion:** `scandone` 10 cycles after `configupdate`, `pll_locked` 20 cycles after `pll_areset` falls. Required: `pll_areset` high exactly 8 cycles, `done` pulses once, `busy` low afterwards.
- **Start while busy:** pulse `start` with `profile`=3 mid-SHIFT. Required: ignored; the shifted image and `rom_address[10:8]` remain the original profile.
- **Reset mid-SHIFT:** assert `reset_n`=0 at bit 70. Required: outputs reach reset values immediately, no `configupdate`, and the next `start` produces a full 144-bit shift.
- **Timeout (macro on):** hold `scandone`=0. Required: after 4096 cycles `error`=1, `busy`=0, no `done`, no `pll_areset`.

Source files
------------

// File: rtl/m10_pll_scan_pkg.sv
// Shared types and constants for the MAX 10 PLL scan-chain controller.
package m10_pll_scan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShift,
    StUpdate,
    StWaitDone,
    StAreset,
    StWaitLock,
    StFail
  } pll_scan_fsm_t;

  localparam int unsigned CHAIN_LEN_C      = 144;
  localparam int unsigned ROM_LATENCY_C    = 2;
  localparam int unsigned ARESET_CYCLES_C  = 8;
  localparam int unsigned TIMEOUT_CYCLES_C = 4096;

  // LTPI link-speed profiles; the ROM holds one scan image per code.
  localparam logic [2:0] PROFILE_0_C = 3'd0;
  localparam logic [2:0] PROFILE_1_C = 3'd1;
  localparam logic [2:0] PROFILE_2_C = 3'd2;
  localparam logic [2:0] PROFILE_3_C = 3'd3;
  localparam logic [2:0] PROFILE_4_C = 3'd4;
  localparam logic [2:0] PROFILE_5_C = 3'd5;
  localparam logic [2:0] PROFILE_6_C = 3'd6;
  localparam logic [2:0] PROFILE_7_C = 3'd7;

endpackage

// File: rtl/m10_pll_scan_timeout.sv
// Load/run/expire wait-bound counter for the PLL scan controller.
module m10_pll_scan_timeout
  import m10_pll_scan_pkg::*;
#(
  parameter int unsigned Cycles = TIMEOUT_CYCLES_C
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam logic [12:0] LastCnt = 13'(Cycles - 1);

  logic [12:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + 13'd1;
    end
  end

  // Fires on the last of Cycles consecutive run cycles.
  assign expired = run && (cnt_q == LastCnt);

endmodule

// File: rtl/m10_pll_scan_ctrl.sv
// MAX 10 PLL dynamic-reconfiguration scan controller: ROM read, shift, update, reset, lock.
// Optional wait timeouts are enabled with `define M10_PLL_SCAN_TIMEOUT_EN.
module m10_pll_scan_ctrl
  import m10_pll_scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN      = CHAIN_LEN_C,
  parameter int unsigned ROM_LATENCY    = ROM_LATENCY_C,
  parameter int unsigned ARESET_CYCLES  = ARESET_CYCLES_C,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_C
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  profile,
  output logic [10:0] rom_address,
  output logic        rom_rden,
  input  logic        rom_q,
  output logic        scandata,
  output logic        scanclkena,
  output logic        configupdate,
  input  logic        scandone,
  output logic        pll_areset,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] LastIdx   = 8'(CHAIN_LEN - 1);
  localparam logic [7:0] LastIdxM1 = 8'(CHAIN_LEN - 2);
  localparam logic [7:0] FirstQIdx = 8'(ROM_LATENCY);
  localparam logic [7:0] ArLast    = 8'(ARESET_CYCLES - 1);

  if (CHAIN_LEN < ROM_LATENCY + 2 || CHAIN_LEN > 256 || ARESET_CYCLES == 0 ||
      ARESET_CYCLES > 256 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 8192) begin : g_bad_params
    $error("m10_pll_scan_ctrl: parameter out of range");
  end

  pll_scan_fsm_t state_q, state_d;
  logic [2:0] prof_q, prof_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] bit_q, bit_d;
  logic [7:0] ar_cnt_q, ar_cnt_d;
  logic rden_q, rden_d;
  logic sdata_q, sdata_d;
  logic sclk_q, sclk_d;
  logic cu_q, cu_d;
  logic areset_q, areset_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic tmo_expired;

`ifdef M10_PLL_SCAN_TIMEOUT_EN
  logic tmo_run;
  logic tmo_load;

  assign tmo_run  = (state_q == StWaitDone) || (state_q == StWaitLock);
  assign tmo_load = !tmo_run;

  m10_pll_scan_timeout #(
    .Cycles(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (tmo_load),
    .run    (tmo_run),
    .expired(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    prof_d   = prof_q;
    idx_d    = idx_q;
    bit_d    = bit_q;
    ar_cnt_d = ar_cnt_q;
    rden_d   = rden_q;
    sdata_d  = sdata_q;
    sclk_d   = 1'b0;
    cu_d     = 1'b0;
    areset_d = 1'b0;
    done_d   = 1'b0;
    error_d  = error_q;

    // ROM address walks up once per read cycle and parks on the last bit.
    if (rden_q && (idx_q != LastIdx)) begin
      idx_d = idx_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          prof_d  = profile;
          idx_d   = '0;
          error_d = 1'b0;
          rden_d  = 1'b1;
        end
      end
      StFetch: begin
        if (idx_q == FirstQIdx) begin
          state_d = StShift;
          sdata_d = rom_q;
          sclk_d  = 1'b1;
          bit_d   = '0;
        end
      end
      StShift: begin
        if (bit_q == LastIdx) begin
          state_d = StUpdate;
          sdata_d = 1'b0;
          cu_d    = 1'b1;
        end else begin
          sdata_d = rom_q;
          sclk_d  = 1'b1;
          bit_d   = bit_q + 8'd1;
          // This edge consumes the final ROM bit; dropping rden earlier restarts the ROM.
          if (bit_q == LastIdxM1) begin
            rden_d = 1'b0;
          end
        end
      end
      StUpdate: begin
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (scandone) begin
          state_d  = StAreset;
          areset_d = 1'b1;
          ar_cnt_d = '0;
        end else if (tmo_expired) begin
          state_d = StFail;
        end
      end
      StAreset: begin
        if (ar_cnt_q == ArLast) begin
          state_d = StWaitLock;
        end else begin
          areset_d = 1'b1;
          ar_cnt_d = ar_cnt_q + 8'd1;
        end
      end
      StWaitLock: begin
        if (pll_locked) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (tmo_expired) begin
          state_d = StFail;
        end
      end
      StFail: begin
        state_d = StIdle;
        error_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);

`ifndef M10_PLL_SCAN_TIMEOUT_EN
    error_d = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      prof_q   <= '0;
      idx_q    <= '0;
      bit_q    <= '0;
      ar_cnt_q <= '0;
      rden_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sclk_q   <= 1'b0;
      cu_q     <= 1'b0;
      areset_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prof_q   <= prof_d;
      idx_q    <= idx_d;
      bit_q    <= bit_d;
      ar_cnt_q <= ar_cnt_d;
      rden_q   <= rden_d;
      sdata_q  <= sdata_d;
      sclk_q   <= sclk_d;
      cu_q     <= cu_d;
      areset_q <= areset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign rom_address  = {prof_q, idx_q};
  assign rom_rden     = rden_q;
  assign scandata     = sdata_q;
  assign scanclkena   = sclk_q;
  assign configupdate = cu_q;
  assign pll_areset   = areset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_m10_pll_scan_ctrl.sv
// Scoreboard bench for m10_pll_scan_ctrl with a behavioural ROM and PLL model.
module tb_m10_pll_scan_ctrl;
  import m10_pll_scan_pkg::*;

  localparam int M_HI = 16, M_LO = 24, C0_HI = 48, C0_LO = 56, C1_HI = 72, C1_LO = 80;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  profile = 3'd0;
  logic [10:0] rom_address;
  logic        rom_rden;
  logic        rom_q = 1'b0;
  logic        scandata, scanclkena, configupdate;
  logic        scandone = 1'b0;
  logic        pll_areset;
  logic        pll_locked = 1'b1;
  logic        busy, done, error;

  always #5 clock = ~clock;

  m10_pll_scan_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .profile     (profile),
    .rom_address (rom_address),
    .rom_rden    (rom_rden),
    .rom_q       (rom_q),
    .scandata    (scandata),
    .scanclkena  (scanclkena),
    .configupdate(configupdate),
    .scandone    (scandone),
    .pll_areset  (pll_areset),
    .pll_locked  (pll_locked),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ROM model: per-profile images, two-stage read pipeline.
  logic [CHAIN_LEN_C-1:0] img [8];
  logic rom_s1 = 1'b0;

  always @(posedge clock) begin
    rom_s1 <= (rom_rden && rom_address[7:0] < 8'(CHAIN_LEN_C)) ?
              img[rom_address[10:8]][rom_address[7:0]] : 1'b0;
    rom_q  <= rom_s1;
  end

  task automatic build_images();
    logic [7:0] m, c;
    for (int p = 0; p < 8; p++) begin
      for (int b = 0; b < CHAIN_LEN_C; b++) img[p][b] = 1'($urandom_range(0, 1));
      m = (p == 0) ? 8'h0C : (p >= 6) ? 8'h14 : 8'(12 + p);
      c = (p == 0) ? 8'h18 : (p >= 6) ? 8'h10 : 8'(24 - p);
      for (int k = 0; k < 8; k++) begin
        img[p][M_HI + k]  = m[k];
        img[p][M_LO + k]  = m[k];
        img[p][C0_HI + k] = c[k];
        img[p][C0_LO + k] = c[k];
        img[p][C1_HI + k] = c[k];
        img[p][C1_LO + k] = c[k];
      end
    end
    img[7]    = img[6];
    img[7][0] = ~img[6][0];
  endtask

  function automatic logic [7:0] fld(input logic [CHAIN_LEN_C-1:0] v, input int pos);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[pos + k];
    return r;
  endfunction

  // PLL model: scandone 10 cycles after configupdate, lock 20 cycles after areset falls.
  bit sd_enable = 1'b1;
  bit sd_force = 1'b0;
  int cu_at = -1;
  int ar_fall = -1;
  logic prev_ar = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        scandone = 1'b0;
        cu_at    = -1;
        ar_fall  = -1;
      end else begin
        if (configupdate) cu_at = cyc;
        if (sd_enable && cu_at >= 0 && cyc == cu_at + 10) begin
          scandone = 1'b1;
          cu_at    = -1;
        end
        if (sd_force) scandone = 1'b1;
        if (pll_areset) begin
          pll_locked = 1'b0;
          scandone   = 1'b0;
        end
        if (prev_ar && !pll_areset) ar_fall = cyc;
        if (ar_fall >= 0 && cyc == ar_fall + 20) begin
          pll_locked = 1'b1;
          ar_fall    = -1;
        end
      end
      prev_ar = pll_areset;
    end
  end

  // Scoreboard
  typedef struct {
    int   at;
    logic b;
  } sd_exp_t;

  sd_exp_t sd_q[$];
  int cu_q[$];
  int run_s = 0;
  logic [2:0] run_prof = 3'd0;
  int rden_cnt, rden_first, rden_last, ar_cnt, done_cnt, done_cyc, cu_cnt;
  logic [CHAIN_LEN_C-1:0] cap;

  initial begin
    sd_exp_t e;
    int k;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (scanclkena) begin
          k = cyc - run_s - 4;
          if (k >= 0 && k < CHAIN_LEN_C) cap[k] = scandata;
          if (sd_q.size() == 0) begin
            check("scandata_unexpected", 32'd1, 32'd0);
          end else begin
            e = sd_q.pop_front();
            check("scandata_cycle", cyc, e.at);
            check("scandata_bit", {31'd0, scandata}, {31'd0, e.b});
          end
        end
        if (configupdate) begin
          cu_cnt++;
          if (cu_q.size() == 0) check("configupdate_unexpected", 32'd1, 32'd0);
          else check("configupdate_cycle", cyc, cu_q.pop_front());
        end
        if (rom_rden) begin
          rden_cnt++;
          if (rden_first < 0) rden_first = cyc;
          rden_last = cyc;
          k = cyc - run_s - 1;
          if (k > CHAIN_LEN_C - 1) k = CHAIN_LEN_C - 1;
          check("rom_address", {21'd0, rom_address}, {21'd0, run_prof, 8'(k)});
        end
        if (pll_areset) ar_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_with_busy_low", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic do_start(input logic [2:0] p);
    @(negedge clock);
    start      = 1'b1;
    profile    = p;
    run_s      = cyc;
    run_prof   = p;
    rden_cnt   = 0;
    rden_first = -1;
    rden_last  = -1;
    ar_cnt     = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    cu_cnt     = 0;
    cap        = '0;
    sd_q.delete();
    cu_q.delete();
    for (int i = 0; i < CHAIN_LEN_C; i++) sd_q.push_back('{at: run_s + 4 + i, b: img[p][i]});
    cu_q.push_back(run_s + 4 + CHAIN_LEN_C);
    @(negedge clock);
    start   = 1'b0;
    profile = 3'($urandom_range(0, 7));
    check("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, output int fall_cyc);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("idle_within_budget", {31'd0, busy}, 32'd0);
    fall_cyc = cyc;
    @(negedge clock);
  endtask

  task automatic full_run(input logic [2:0] p, input bit poke_start);
    int fall;
    do_start(p);
    if (poke_start) begin
      repeat (48) @(negedge clock);
      start   = 1'b1;
      profile = PROFILE_3_C;
      @(negedge clock);
      start = 1'b0;
    end
    wait_idle(600, fall);
    check("sd_missing", sd_q.size(), 0);
    check("configupdate_count", cu_cnt, 1);
    check("rden_count", rden_cnt, CHAIN_LEN_C + ROM_LATENCY_C);
    check("rden_first", rden_first, run_s + 1);
    check("rden_last", rden_last, run_s + CHAIN_LEN_C + ROM_LATENCY_C);
    check("areset_width", ar_cnt, ARESET_CYCLES_C);
    check("done_count", done_cnt, 1);
    check("done_at_busy_fall", done_cyc, fall);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("error_after", {31'd0, error}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_address"}, {21'd0, rom_address}, 32'd0);
    check({tag, "_rom_rden"}, {31'd0, rom_rden}, 32'd0);
    check({tag, "_scandata"}, {31'd0, scandata}, 32'd0);
    check({tag, "_scanclkena"}, {31'd0, scanclkena}, 32'd0);
    check({tag, "_configupdate"}, {31'd0, configupdate}, 32'd0);
    check({tag, "_pll_areset"}, {31'd0, pll_areset}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched",
             n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int fall;
    build_images();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    full_run(PROFILE_0_C, 1'b0);
    check("p0_m_hi", {24'd0, fld(cap, M_HI)}, 32'h0C);
    check("p0_m_lo", {24'd0, fld(cap, M_LO)}, 32'h0C);
    check("p0_c0_hi", {24'd0, fld(cap, C0_HI)}, 32'h18);
    check("p0_c0_lo", {24'd0, fld(cap, C0_LO)}, 32'h18);
    check("p0_c1_hi", {24'd0, fld(cap, C1_HI)}, 32'h18);
    check("p0_c1_lo", {24'd0, fld(cap, C1_LO)}, 32'h18);

    full_run(PROFILE_6_C, 1'b0);
    check("p6_m_hi", {24'd0, fld(cap, M_HI)}, 32'h14);
    check("p6_c0_hi", {24'd0, fld(cap, C0_HI)}, 32'h10);
    full_run(PROFILE_7_C, 1'b0);
    check("p7_m_hi", {24'd0, fld(cap, M_HI)}, 32'h14);
    check("p7_c0_hi", {24'd0, fld(cap, C0_HI)}, 32'h10);
    check("p7_c1_lo", {24'd0, fld(cap, C1_LO)}, 32'h10);

    full_run(3'($urandom_range(0, 2)), 1'b1);

    // Reset while bit 70 is on scandata.
    do_start(3'($urandom_range(0, 7)));
    while (cyc < run_s + 4 + 70) @(negedge clock);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sd_q.delete();
    cu_q.delete();
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    cu_cnt = 0;
    repeat (160) @(negedge clock);
    check("midreset_no_configupdate", cu_cnt, 0);
    check("midreset_idle", {31'd0, busy}, 32'd0);
    full_run(3'($urandom_range(0, 7)), 1'b0);

    // Withhold scandone.
    sd_enable = 1'b0;
    do_start(3'($urandom_range(0, 7)));
    repeat (CHAIN_LEN_C + 8) @(negedge clock);
    check("hold_configupdate_seen", cu_cnt, 1);
`ifdef M10_PLL_SCAN_TIMEOUT_EN
    wait_idle(4300, fall);
    check("timeout_error", {31'd0, error}, 32'd1);
    check("timeout_window", {31'd0, (fall >= run_s + 148 + 4096) && (fall <= run_s + 148 + 4100)},
          32'd1);
    check("timeout_no_done", done_cnt, 0);
    check("timeout_no_areset", ar_cnt, 0);
    repeat (5) @(negedge clock);
    check("timeout_error_sticky", {31'd0, error}, 32'd1);
    sd_enable = 1'b1;
`else
    repeat (5000) @(negedge clock);
    check("nowait_bound_busy", {31'd0, busy}, 32'd1);
    check("nowait_bound_error", {31'd0, error}, 32'd0);
    check("nowait_bound_areset", ar_cnt, 0);
    sd_force = 1'b1;
    wait_idle(200, fall);
    sd_force = 1'b0;
    check("late_scandone_done", done_cnt, 1);
    check("late_scandone_areset", ar_cnt, ARESET_CYCLES_C);
    sd_enable = 1'b1;
`endif

    full_run(3'($urandom_range(0, 7)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
